// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e   : sequencer state, encoding is visible on state_dbg
//   LossCountMax  : saturation value of the lock-loss counter
//   clog2_fn      : ceil(log2(value)), used for elaboration-time width checks
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StFilter   = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3,
    StPllRst   = 3'd4
  } seq_state_e;

  localparam int unsigned LossCountMax = 255;

  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into clk_i.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear of both stages
//   d_i    : asynchronous level input
//   q_o    : synchronised level, two destination cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock filter and staggered domain-reset release.
//   clk             : free-running reference clock
//   resetn          : asynchronous active-low reset
//   pll_locked      : raw PLL lock, asynchronous to clk
//   sw_reset_req    : one-cycle request to re-run the release (honoured in RUN only)
//   domain_resetn   : per-domain active-low resets, index 0 released first
//   all_ready       : all domains released and sequencer in RUN
//   pll_areset      : active-high PLL reset pulse after a relock timeout
//   lock_loss_count : saturating count of lock losses seen in RUN
//   state_dbg       : current state encoding
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS        = 2,
  parameter int unsigned LOCK_FILTER_CYCLES = 1024,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned RELOCK_TIMEOUT     = 65536,
  parameter int unsigned ARESET_CYCLES      = 8,
  parameter int unsigned CNT_W              = 17
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   all_ready,
  output logic                   pll_areset,
  output logic [7:0]             lock_loss_count,
  output logic [2:0]             state_dbg
);

  localparam int unsigned ReleaseSpan = STAGGER_CYCLES * NUM_DOMAINS;
  localparam int unsigned MaxA = (LOCK_FILTER_CYCLES > RELOCK_TIMEOUT) ?
                                 LOCK_FILTER_CYCLES : RELOCK_TIMEOUT;
  localparam int unsigned MaxB = (ARESET_CYCLES > ReleaseSpan) ? ARESET_CYCLES : ReleaseSpan;
  localparam int unsigned MaxCount = (MaxA > MaxB) ? MaxA : MaxB;

  if (NUM_DOMAINS == 0 || NUM_DOMAINS > 8) begin : g_bad_num_domains
    $error("NUM_DOMAINS must be in 1..8");
  end
  if (LOCK_FILTER_CYCLES == 0 || STAGGER_CYCLES == 0 || RELOCK_TIMEOUT == 0) begin : g_bad_count
    $error("LOCK_FILTER_CYCLES, STAGGER_CYCLES and RELOCK_TIMEOUT must be >= 1");
  end
  if (CNT_W < clog2_fn(MaxCount + 1)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the largest count");
  end

  // The lock cycle that moved us into FILTER already counts as the first filtered cycle.
  localparam int unsigned FilterLast = (LOCK_FILTER_CYCLES >= 2) ? LOCK_FILTER_CYCLES - 2 : 0;

  localparam logic [CNT_W-1:0] FilterLastC  = CNT_W'(FilterLast);
  localparam logic [CNT_W-1:0] TimeoutLastC = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AresetC      = CNT_W'(ARESET_CYCLES);
  localparam logic [CNT_W-1:0] ReleaseDoneC = CNT_W'(ReleaseSpan);
  localparam logic [CNT_W-1:0] CntOne       = CNT_W'(1);

  logic                   lock_s;
  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   areset_q, areset_d;
  logic [7:0]             loss_q, loss_d;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StWaitLock;
      cnt_q    <= '0;
      dom_q    <= '0;
      ready_q  <= 1'b0;
      areset_q <= 1'b0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dom_q    <= dom_d;
      ready_q  <= ready_d;
      areset_q <= areset_d;
      loss_q   <= loss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dom_d    = dom_q;
    ready_d  = ready_q;
    areset_d = 1'b0;
    loss_d   = loss_q;

    unique case (state_q)
      StWaitLock: begin
        dom_d   = '0;
        ready_d = 1'b0;
        if (lock_s) begin
          state_d = StFilter;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLastC) begin
          state_d  = StPllRst;
          cnt_d    = '0;
          areset_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StFilter: begin
        // A dropout is a filter restart, not a loss.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q >= FilterLastC) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StRelease: begin
        if (!lock_s) begin
          dom_d   = '0;
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
          // Thresholds rise with k, so released bits always form a thermometer from bit 0.
          for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
            if (cnt_d >= CNT_W'(STAGGER_CYCLES * (k + 1))) begin
              dom_d[k] = 1'b1;
            end
          end
          if (cnt_d == ReleaseDoneC) begin
            ready_d = 1'b1;
            state_d = StRun;
            cnt_d   = '0;
          end
        end
      end

      StRun: begin
        // Lock loss takes priority over a simultaneous software request.
        if (!lock_s) begin
          dom_d   = '0;
          ready_d = 1'b0;
          state_d = StWaitLock;
          cnt_d   = '0;
          if (loss_q != 8'(LossCountMax)) begin
            loss_d = loss_q + 8'd1;
          end
        end else if (sw_reset_req) begin
          dom_d   = '0;
          ready_d = 1'b0;
          state_d = StFilter;
          cnt_d   = '0;
        end
      end

      StPllRst: begin
        // Pulse for ARESET_CYCLES, then one quiet cycle before relock waiting resumes.
        dom_d   = '0;
        ready_d = 1'b0;
        if (cnt_q == AresetC) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CntOne;
          areset_d = (cnt_d < AresetC);
        end
      end

      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
        dom_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign domain_resetn   = dom_q;
  assign all_ready       = ready_q;
  assign pll_areset      = areset_q;
  assign lock_loss_count = loss_q;
  assign state_dbg       = state_q;

endmodule
